// File: rtl/pc_defs.sv
// Shared encodings for the next-PC predictor: counter states, BTB write ops and PC increment.
package pc_defs;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  typedef enum logic [1:0] {
    BTB_NONE      = 2'b00,
    BTB_JUMP      = 2'b01,
    BTB_TAKEN     = 2'b10,
    BTB_NOT_TAKEN = 2'b11
  } btb_op_e;

  localparam int PC_INCR = 4;

  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST) ? ctr : ctr + 2'd1;
    return (ctr == CTR_SNT) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational lookup by fetch index/tag, one synchronous
// read-modify-write port driven by the resolved EX-stage instruction.
module branch_target_buffer
  import pc_defs::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 26
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit,
  output logic             rd_uncond,
  output logic [1:0]       rd_ctr,
  output logic [XLEN-1:0]  rd_target,
  input  btb_op_e          wr_op,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [XLEN-1:0]  wr_target
);

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic             uncond_q [ENTRIES];
  logic             uncond_d [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [XLEN-1:0]  target_d [ENTRIES];
  logic             wr_hit;

  // Lookup reads only the registered contents, so a same-index update is seen next cycle.
  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_uncond = uncond_q[rd_idx];
  assign rd_ctr    = ctr_q[rd_idx];
  assign rd_target = target_q[rd_idx];
  assign wr_hit    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  always_comb begin
    valid_d  = valid_q;
    uncond_d = uncond_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    unique case (wr_op)
      BTB_JUMP: begin
        valid_d[wr_idx]  = 1'b1;
        tag_d[wr_idx]    = wr_tag;
        target_d[wr_idx] = wr_target;
        uncond_d[wr_idx] = 1'b1;
        ctr_d[wr_idx]    = CTR_ST;
      end
      BTB_TAKEN: begin
        target_d[wr_idx] = wr_target;
        if (wr_hit) begin
          ctr_d[wr_idx] = ctr_update(ctr_q[wr_idx], 1'b1);
        end else begin
          valid_d[wr_idx]  = 1'b1;
          tag_d[wr_idx]    = wr_tag;
          uncond_d[wr_idx] = 1'b0;
          ctr_d[wr_idx]    = CTR_WT;
        end
      end
      BTB_NOT_TAKEN: begin
        if (wr_hit) ctr_d[wr_idx] = ctr_update(ctr_q[wr_idx], 1'b0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        uncond_q[i] <= 1'b0;
        ctr_q[i]    <= CTR_WNT;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      uncond_q <= uncond_d;
      ctr_q    <= ctr_d;
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

endmodule

// File: rtl/next_pc_predictor.sv
// Fetch PC register with BTB-based next-PC prediction and EX-stage resolve/redirect.
module next_pc_predictor
  import pc_defs::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_next_pc,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic            ex_bcond,
  input  logic [XLEN-1:0] ex_target,
  input  logic [XLEN-1:0] ex_jalr_target,
  input  logic [XLEN-1:0] ex_pred_next_pc,
  output logic            flush
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] actual_next_pc;
  logic            rd_hit, rd_uncond;
  logic [1:0]      rd_ctr;
  logic [XLEN-1:0] rd_target;
  btb_op_e         btb_op;

  branch_target_buffer #(
    .XLEN   (XLEN),
    .ENTRIES(BTB_ENTRIES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W)
  ) u_btb (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_idx   (pc_q[IDX_W+1:2]),
    .rd_tag   (pc_q[XLEN-1:IDX_W+2]),
    .rd_hit   (rd_hit),
    .rd_uncond(rd_uncond),
    .rd_ctr   (rd_ctr),
    .rd_target(rd_target),
    .wr_op    (btb_op),
    .wr_idx   (ex_pc[IDX_W+1:2]),
    .wr_tag   (ex_pc[XLEN-1:IDX_W+2]),
    .wr_target(actual_next_pc)
  );

  assign pc           = pc_q;
  assign pred_taken   = rd_hit && (rd_uncond || rd_ctr[1]);
  assign pred_next_pc = pred_taken ? rd_target : pc_q + XLEN'(PC_INCR);

  always_comb begin
    actual_next_pc = ex_pc + XLEN'(PC_INCR);
    if (ex_is_jalr) actual_next_pc = ex_jalr_target;
    else if ((ex_is_branch && ex_bcond) || ex_is_jal) actual_next_pc = ex_target;
  end

  // Wrong direction and wrong target both surface as a next-PC mismatch.
  assign flush = reset_n && ex_valid && (actual_next_pc != ex_pred_next_pc);

  always_comb begin
    btb_op = BTB_NONE;
    if (ex_valid) begin
      if (ex_is_jal || ex_is_jalr) btb_op = BTB_JUMP;
      else if (ex_is_branch)       btb_op = ex_bcond ? BTB_TAKEN : BTB_NOT_TAKEN;
    end
  end

  always_comb begin
    pc_d = pred_next_pc;
    if (flush)      pc_d = actual_next_pc;
    else if (stall) pc_d = pc_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc_q <= RESET_PC;
    else          pc_q <= pc_d;
  end

endmodule

// File: tb/tb_next_pc_predictor.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural BTB/PC model.
module tb_next_pc_predictor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_branch, ex_is_jal, ex_is_jalr, ex_bcond;
  logic [31:0] ex_target, ex_jalr_target, ex_pred_next_pc;
  logic        flush;

  int checks   = 0;
  int failures = 0;

  next_pc_predictor dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .pc             (pc),
    .pred_taken     (pred_taken),
    .pred_next_pc   (pred_next_pc),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jal      (ex_is_jal),
    .ex_is_jalr     (ex_is_jalr),
    .ex_bcond       (ex_bcond),
    .ex_target      (ex_target),
    .ex_jalr_target (ex_jalr_target),
    .ex_pred_next_pc(ex_pred_next_pc),
    .flush          (flush)
  );

  always #5 clk = ~clk;

  // Behavioural model: a 16-entry table addressed by (pc/4) mod 16, tagged by pc/64.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  bit          m_unc   [16];
  int          m_ctr   [16];
  logic [31:0] m_pc;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_unc[i] = 0; m_ctr[i] = 1;
    end
    m_pc = 32'h0;
  endfunction

  function automatic void model_lookup(input logic [31:0] a, output bit tk, output logic [31:0] nxt);
    int i = int'((a / 4) % 16);
    bit hit = m_valid[i] && (m_tag[i] == a / 64);
    tk  = hit && (m_unc[i] || m_ctr[i] >= 2);
    nxt = tk ? m_tgt[i] : a + 32'd4;
  endfunction

  function automatic logic [31:0] model_actual();
    if (ex_is_jalr) return ex_jalr_target;
    if ((ex_is_branch && ex_bcond) || ex_is_jal) return ex_target;
    return ex_pc + 32'd4;
  endfunction

  function automatic bit model_flush();
    return ex_valid && (model_actual() != ex_pred_next_pc);
  endfunction

  task automatic clear_ex();
    ex_valid = 0; ex_pc = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
    ex_bcond = 0; ex_target = 0; ex_jalr_target = 0; ex_pred_next_pc = 0;
  endtask

  // Advance one clock edge, moving the model along with the DUT.
  task automatic tick();
    bit          tk;
    logic [31:0] nxt, act, new_pc;
    int          i;
    model_lookup(m_pc, tk, nxt);
    act    = model_actual();
    new_pc = model_flush() ? act : (stall ? m_pc : nxt);
    if (ex_valid && (ex_is_branch || ex_is_jal || ex_is_jalr)) begin
      i = int'((ex_pc / 4) % 16);
      if (ex_is_jal || ex_is_jalr) begin
        m_valid[i] = 1; m_tag[i] = ex_pc / 64; m_tgt[i] = act; m_unc[i] = 1; m_ctr[i] = 3;
      end else if (m_valid[i] && m_tag[i] == ex_pc / 64) begin
        m_ctr[i] = ex_bcond ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
        if (ex_bcond) m_tgt[i] = ex_target;
      end else if (ex_bcond) begin
        m_valid[i] = 1; m_tag[i] = ex_pc / 64; m_tgt[i] = ex_target; m_unc[i] = 0; m_ctr[i] = 2;
      end
    end
    @(posedge clk);
    m_pc = new_pc;
    #1;
  endtask

  // Steer fetch to addr via a mispredicted non-control instruction in EX.
  task automatic redirect(input logic [31:0] addr);
    clear_ex();
    ex_valid = 1; ex_pc = addr - 32'd4; ex_pred_next_pc = ~addr;
    tick();
    clear_ex();
  endtask

  task automatic test_reset();
    reset_n = 0; stall = 0; clear_ex(); model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    #1;
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h want 00000000", pc); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (pc !== 32'(4 * k)) begin failures++; $display("FAIL reset_step: got %h want %h", pc, 32'(4 * k)); end
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred: got %b want 0", pred_taken); end
    end
    ex_valid = 1; ex_pc = 32'h8; ex_pred_next_pc = 32'h0;
    #1;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL pre_reset_flush: got %b want 1", flush); end
    #2 reset_n = 0;
    #1;
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL async_reset_pc: got %h want 00000000", pc); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush: got %b want 0", flush); end
    @(posedge clk); #1;
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_hold: got %h want 00000000", pc); end
    clear_ex(); model_reset();
    reset_n = 1;
    #1;
    tick();
    checks++; if (pc !== 32'h4) begin failures++; $display("FAIL post_reset_step: got %h want 00000004", pc); end
  endtask

  task automatic test_cold_branch();
    ex_valid = 1; ex_pc = 32'h10; ex_is_branch = 1; ex_bcond = 1;
    ex_target = 32'h40; ex_pred_next_pc = 32'h14;
    #1;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL cold_flush: got %b want 1", flush); end
    tick();
    checks++; if (pc !== 32'h40) begin failures++; $display("FAIL cold_redirect: got %h want 00000040", pc); end
    redirect(32'h10);
    #1;
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL cold_refetch_taken: got %b want 1", pred_taken); end
    checks++; if (pred_next_pc !== 32'h40) begin failures++; $display("FAIL cold_refetch_target: got %h want 00000040", pred_next_pc); end
  endtask

  task automatic test_branch_train();
    clear_ex();
    ex_valid = 1; ex_pc = 32'h10; ex_is_branch = 1; ex_bcond = 1;
    ex_target = 32'h40; ex_pred_next_pc = 32'h40;
    #1;
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL train_no_flush: got %b want 0", flush); end
    tick();
    ex_bcond = 0;
    #1;
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL not_taken_flush: got %b want 1", flush); end
    tick();
    checks++; if (pc !== 32'h14) begin failures++; $display("FAIL not_taken_pc: got %h want 00000014", pc); end
    redirect(32'h10);
    #1;
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL weak_taken_pred: got %b want 1", pred_taken); end
    checks++; if (pred_next_pc !== 32'h40) begin failures++; $display("FAIL weak_taken_target: got %h want 00000040", pred_next_pc); end
  endtask

  task automatic test_jalr();
    logic [31:0] prev = 32'h24;
    logic [31:0] t;
    for (int k = 0; k < 4; k++) begin
      t = (k % 2 == 0) ? 32'h100 : 32'h200;
      clear_ex();
      ex_valid = 1; ex_pc = 32'h20; ex_is_jalr = 1; ex_jalr_target = t; ex_pred_next_pc = prev;
      #1;
      checks++; if (flush !== 1'b1) begin failures++; $display("FAIL jalr_flush[%0d]: got %b want 1", k, flush); end
      tick();
      checks++; if (pc !== t) begin failures++; $display("FAIL jalr_pc[%0d]: got %h want %h", k, pc, t); end
      redirect(32'h20);
      #1;
      checks++; if (pred_next_pc !== t) begin failures++; $display("FAIL jalr_btb[%0d]: got %h want %h", k, pred_next_pc, t); end
      prev = t;
    end
  endtask

  task automatic test_stall_flush();
    logic [31:0] held;
    clear_ex();
    stall = 1; ex_valid = 1; ex_pc = 32'h50; ex_pred_next_pc = 32'h99;
    tick();
    checks++; if (pc !== 32'h54) begin failures++; $display("FAIL stall_flush_pc: got %h want 00000054", pc); end
    clear_ex();
    held = 32'h54;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (pc !== held) begin failures++; $display("FAIL stall_hold[%0d]: got %h want %h", k, pc, held); end
    end
    stall = 0;
  endtask

  task automatic test_wrap_alias();
    redirect(32'hFFFF_FFFC);
    #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL wrap_pred: got %b want 0", pred_taken); end
    checks++; if (pred_next_pc !== 32'h0) begin failures++; $display("FAIL wrap_next: got %h want 00000000", pred_next_pc); end
    tick();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap_pc: got %h want 00000000", pc); end
    ex_valid = 1; ex_pc = 32'h400; ex_is_jal = 1; ex_target = 32'h800; ex_pred_next_pc = 32'h404;
    tick();
    redirect(32'h40);
    #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL alias_pred: got %b want 0", pred_taken); end
    checks++; if (pred_next_pc !== 32'h44) begin failures++; $display("FAIL alias_next: got %h want 00000044", pred_next_pc); end
    redirect(32'h400);
    #1;
    checks++; if (pred_next_pc !== 32'h800) begin failures++; $display("FAIL alias_owner: got %h want 00000800", pred_next_pc); end
  endtask

  task automatic test_random();
    logic [31:0] pc_pool  [8] = '{32'h100, 32'h104, 32'h140, 32'h208, 32'h30C, 32'h1000, 32'h1004, 32'h2048};
    logic [31:0] tgt_pool [6] = '{32'h100, 32'h140, 32'h208, 32'h1000, 32'h2048, 32'h3000};
    bit          tk;
    logic [31:0] nxt;
    int          kind;
    for (int n = 0; n < 400; n++) begin
      clear_ex();
      stall          = ($urandom % 5) == 0;
      ex_valid       = ($urandom % 4) != 0;
      kind           = int'($urandom % 5);
      ex_pc          = pc_pool[$urandom % 8];
      ex_is_branch   = (kind == 1 || kind == 2);
      ex_is_jal      = (kind == 3);
      ex_is_jalr     = (kind == 4);
      ex_bcond       = $urandom % 2;
      ex_target      = tgt_pool[$urandom % 6];
      ex_jalr_target = tgt_pool[$urandom % 6];
      ex_pred_next_pc = ($urandom % 2) ? model_actual() : tgt_pool[$urandom % 6];
      #1;
      model_lookup(m_pc, tk, nxt);
      checks++; if (pc !== m_pc) begin failures++; $display("FAIL rand_pc[%0d]: got %h want %h", n, pc, m_pc); end
      checks++; if (pred_taken !== tk) begin failures++; $display("FAIL rand_taken[%0d]: got %b want %b", n, pred_taken, tk); end
      checks++; if (pred_next_pc !== nxt) begin failures++; $display("FAIL rand_next[%0d]: got %h want %h", n, pred_next_pc, nxt); end
      checks++; if (flush !== model_flush()) begin failures++; $display("FAIL rand_flush[%0d]: got %b want %b", n, flush, model_flush()); end
      tick();
    end
    clear_ex();
    stall = 0;
  endtask

  initial begin
    test_reset();
    test_cold_branch();
    test_branch_train();
    test_jalr();
    test_stall_flush();
    test_wrap_alias();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
